// File: rtl/arrow_pkg.sv
// arrow_pkg: shared types and constants for the scrolling-arrow engine.
//   dir_e      : arrow travel direction (matches the 2-bit spawn/hit encodings)
//   COLOUR_*   : RGB444 sprite colour per direction
//   slot_t     : per-slot architectural state
//   dir_colour : direction -> sprite colour lookup
package arrow_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'b00,
        DIR_UP    = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    localparam logic [11:0] COLOUR_DOWN  = 12'hF00;
    localparam logic [11:0] COLOUR_UP    = 12'h0F0;
    localparam logic [11:0] COLOUR_RIGHT = 12'h00F;
    localparam logic [11:0] COLOUR_LEFT  = 12'hFF0;

    typedef struct packed {
        logic        active;
        dir_e        dir;
        logic [2:0]  speed;
        logic [10:0] x;
        logic [9:0]  y;
    } slot_t;

    function automatic logic [11:0] dir_colour(input dir_e d);
        logic [11:0] c;
        case (d)
            DIR_DOWN:  c = COLOUR_DOWN;
            DIR_UP:    c = COLOUR_UP;
            DIR_RIGHT: c = COLOUR_RIGHT;
            default:   c = COLOUR_LEFT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/arrow_slot.sv
// arrow_slot: one arrow sprite slot.
// Holds active/direction/speed/position, moves or retires on a frame tick,
// tests whether the current pixel is inside the sprite box and whether the
// arrow sits inside the hit window for a press in its direction.
// Ports:
//   clk, rst_in              : clock, async active-high reset
//   spawn_in                 : load this slot (only asserted while inactive)
//   spawn_dir_in/speed_in    : parameters of the arrow being loaded
//   tick_in                  : frame tick
//   hit_clr_in               : this slot won the hit arbitration, free it
//   hcount_in/vcount_in      : current pixel
//   hit_dir_in               : direction of the current press
//   active_out, dir_out      : registered state for the top-level muxes
//   in_box_out               : active and pixel inside box
//   hit_cand_out             : active, direction match, inside hit window
//   retire_out               : leaves the screen on this tick (counts a miss)
module arrow_slot
    import arrow_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 32,
    parameter int SCREEN_W   = 1280,
    parameter int SCREEN_H   = 720,
    parameter int CENTER_X   = 512,
    parameter int CENTER_Y   = 384,
    parameter int HIT_WINDOW = 16
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        spawn_in,
    input  logic [1:0]  spawn_dir_in,
    input  logic [2:0]  spawn_speed_in,
    input  logic        tick_in,
    input  logic        hit_clr_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [1:0]  hit_dir_in,
    output logic        active_out,
    output logic [1:0]  dir_out,
    output logic        in_box_out,
    output logic        hit_cand_out,
    output logic        retire_out
);

    localparam logic [11:0] SW12    = 12'(SCREEN_W);
    localparam logic [10:0] SH11    = 11'(SCREEN_H);
    localparam logic [11:0] CX12    = 12'(CENTER_X);
    localparam logic [11:0] CY12    = 12'(CENTER_Y);
    localparam logic [11:0] WIN12   = 12'(HIT_WINDOW);
    localparam logic [11:0] W12     = 12'(WIDTH);
    localparam logic [10:0] H11     = 11'(HEIGHT);
    localparam logic [10:0] CX11    = 11'(CENTER_X);
    localparam logic [9:0]  CY10    = 10'(CENTER_Y);
    localparam logic [10:0] X_LEFT0 = 11'(SCREEN_W - WIDTH);
    localparam logic [9:0]  Y_UP0   = 10'(SCREEN_H - HEIGHT);

    slot_t slot_q, slot_d;

    logic [11:0] x_plus;
    logic [10:0] y_plus;
    logic        off_screen;
    logic [11:0] pos, tgt, diff, mag;

    // Next-position arithmetic is widened one bit so the screen-edge test
    // cannot wrap.
    always_comb begin
        x_plus = {1'b0, slot_q.x} + {9'd0, slot_q.speed};
        y_plus = {1'b0, slot_q.y} + {8'd0, slot_q.speed};
        case (slot_q.dir)
            DIR_DOWN:  off_screen = (y_plus >= SH11);
            DIR_UP:    off_screen = (slot_q.y < {7'd0, slot_q.speed});
            DIR_RIGHT: off_screen = (x_plus >= SW12);
            default:   off_screen = (slot_q.x < {8'd0, slot_q.speed});
        endcase
    end

    // A slot claimed by a hit this cycle is neither moved nor retired.
    assign retire_out = slot_q.active && tick_in && !hit_clr_in && off_screen;

    always_comb begin
        slot_d = slot_q;
        if (spawn_in) begin
            slot_d.active = 1'b1;
            slot_d.dir    = dir_e'(spawn_dir_in);
            slot_d.speed  = spawn_speed_in;
            case (dir_e'(spawn_dir_in))
                DIR_DOWN:  begin slot_d.x = CX11;  slot_d.y = 10'd0; end
                DIR_UP:    begin slot_d.x = CX11;  slot_d.y = Y_UP0; end
                DIR_RIGHT: begin slot_d.x = 11'd0; slot_d.y = CY10;  end
                default:   begin slot_d.x = X_LEFT0; slot_d.y = CY10; end
            endcase
        end else if (hit_clr_in) begin
            slot_d.active = 1'b0;
        end else if (slot_q.active && tick_in) begin
            if (off_screen) begin
                slot_d.active = 1'b0;
            end else begin
                case (slot_q.dir)
                    DIR_DOWN:  slot_d.y = y_plus[9:0];
                    DIR_UP:    slot_d.y = slot_q.y - {7'd0, slot_q.speed};
                    DIR_RIGHT: slot_d.x = x_plus[10:0];
                    default:   slot_d.x = slot_q.x - {8'd0, slot_q.speed};
                endcase
            end
        end
    end

    // Hit window: distance along the travel axis, evaluated as a 12-bit
    // two's-complement difference.
    always_comb begin
        pos  = slot_q.dir[1] ? {1'b0, slot_q.x} : {2'b0, slot_q.y};
        tgt  = slot_q.dir[1] ? CX12 : CY12;
        diff = pos - tgt;
        mag  = diff[11] ? (~diff + 12'd1) : diff;
    end

    assign hit_cand_out = slot_q.active && (slot_q.dir == dir_e'(hit_dir_in)) &&
                          (mag <= WIN12);

    assign in_box_out = slot_q.active &&
                        ({1'b0, hcount_in} >= {1'b0, slot_q.x}) &&
                        ({1'b0, hcount_in} <= ({1'b0, slot_q.x} + W12)) &&
                        ({1'b0, vcount_in} >= {1'b0, slot_q.y}) &&
                        ({1'b0, vcount_in} <= ({1'b0, slot_q.y} + H11));

    assign active_out = slot_q.active;
    assign dir_out    = slot_q.dir;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) slot_q <= '0;
        else        slot_q <= slot_d;
    end

endmodule

// File: rtl/arrow_field.sv
// arrow_field: multi-slot scrolling-arrow engine.
// Spawns arrows into free slots via valid/ready, advances them each frame,
// scores presses against the target window, retires off-screen arrows as
// misses and drives a registered RGB444 pixel stream.
// Ports:
//   clk, rst_in                      : pixel clock, async active-high reset
//   hcount_in, vcount_in             : current pixel (tick at 0,0)
//   spawn_valid_in/ready_out         : spawn handshake
//   spawn_direction_in/speed_in      : new arrow parameters
//   hit_in, hit_direction_in         : player press
//   pixel_out, valid_out             : topmost covering arrow, 1-cycle latency
//   hit_out, miss_out                : one-cycle score pulses
//   hit_count_out, miss_count_out    : saturating totals
module arrow_field
    import arrow_pkg::*;
#(
    parameter int NUM_ARROWS = 4,
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 32,
    parameter int SCREEN_W   = 1280,
    parameter int SCREEN_H   = 720,
    parameter int CENTER_X   = 512,
    parameter int CENTER_Y   = 384,
    parameter int HIT_WINDOW = 16
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        spawn_valid_in,
    output logic        spawn_ready_out,
    input  logic [1:0]  spawn_direction_in,
    input  logic [2:0]  spawn_speed_in,
    input  logic        hit_in,
    input  logic [1:0]  hit_direction_in,
    output logic [11:0] pixel_out,
    output logic        valid_out,
    output logic        hit_out,
    output logic        miss_out,
    output logic [15:0] hit_count_out,
    output logic [15:0] miss_count_out
);

    logic [NUM_ARROWS-1:0]      active, in_box, hit_cand, retire;
    logic [NUM_ARROWS-1:0]      spawn_vec, hit_vec;
    logic [NUM_ARROWS-1:0][1:0] dir;
    logic                       tick, spawn_fire;

    logic [11:0] pixel_d, pixel_q;
    logic        valid_d, valid_q;
    logic        hit_d, hit_q;
    logic        miss_d, miss_q;
    logic [15:0] hit_cnt_d, hit_cnt_q;
    logic [15:0] miss_cnt_d, miss_cnt_q;
    logic [3:0]  n_retire;
    logic [16:0] miss_sum;

    assign tick            = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign spawn_ready_out = ~&active;
    assign spawn_fire      = spawn_valid_in && spawn_ready_out && !rst_in;

    // Lowest-index free slot for spawns, lowest-index candidate for hits.
    // Loops run high-to-low so the lowest match is the last assignment.
    always_comb begin
        spawn_vec = '0;
        hit_vec   = '0;
        for (int i = NUM_ARROWS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                spawn_vec    = '0;
                spawn_vec[i] = spawn_fire;
            end
            if (hit_cand[i]) begin
                hit_vec    = '0;
                hit_vec[i] = hit_in;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_ARROWS; g++) begin : g_slot
            arrow_slot #(
                .WIDTH     (WIDTH),
                .HEIGHT    (HEIGHT),
                .SCREEN_W  (SCREEN_W),
                .SCREEN_H  (SCREEN_H),
                .CENTER_X  (CENTER_X),
                .CENTER_Y  (CENTER_Y),
                .HIT_WINDOW(HIT_WINDOW)
            ) u_slot (
                .clk           (clk),
                .rst_in        (rst_in),
                .spawn_in      (spawn_vec[g]),
                .spawn_dir_in  (spawn_direction_in),
                .spawn_speed_in(spawn_speed_in),
                .tick_in       (tick),
                .hit_clr_in    (hit_vec[g]),
                .hcount_in     (hcount_in),
                .vcount_in     (vcount_in),
                .hit_dir_in    (hit_direction_in),
                .active_out    (active[g]),
                .dir_out       (dir[g]),
                .in_box_out    (in_box[g]),
                .hit_cand_out  (hit_cand[g]),
                .retire_out    (retire[g])
            );
        end
    endgenerate

    // Pixel priority mux: lowest index on top.
    always_comb begin
        pixel_d = 12'h000;
        valid_d = 1'b0;
        for (int i = NUM_ARROWS - 1; i >= 0; i--) begin
            if (in_box[i]) begin
                pixel_d = dir_colour(dir_e'(dir[i]));
                valid_d = 1'b1;
            end
        end
    end

    // Scoring: several slots can retire on one tick, so misses add a count.
    always_comb begin
        n_retire = 4'd0;
        for (int i = 0; i < NUM_ARROWS; i++) begin
            n_retire = n_retire + {3'd0, retire[i]};
        end
        hit_d      = |hit_vec;
        miss_d     = |retire;
        hit_cnt_d  = (hit_d && hit_cnt_q != 16'hFFFF) ? hit_cnt_q + 16'd1 : hit_cnt_q;
        miss_sum   = {1'b0, miss_cnt_q} + {13'd0, n_retire};
        miss_cnt_d = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            pixel_q    <= 12'h000;
            valid_q    <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            hit_cnt_q  <= 16'd0;
            miss_cnt_q <= 16'd0;
        end else begin
            pixel_q    <= pixel_d;
            valid_q    <= valid_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign pixel_out      = pixel_q;
    assign valid_out      = valid_q;
    assign hit_out        = hit_q;
    assign miss_out       = miss_q;
    assign hit_count_out  = hit_cnt_q;
    assign miss_count_out = miss_cnt_q;

endmodule

// File: doc/arrow_field.md
# arrow_field

Multi-slot scrolling-arrow engine for the rhythm-game video path. It holds up to `NUM_ARROWS` independently moving arrow sprites and spawns them through a valid/ready handshake. Each frame it advances them by a per-arrow speed, scores player presses against a target window and retires arrows that leave the screen as misses. It sits between the game-control FSM and the pixel mixer and drives one registered 12-bit pixel stream plus hit/miss scoring.

## Interface
- `NUM_ARROWS`, 4: number of arrow slots (1–8).
- `WIDTH`, 8: sprite width in pixels; box spans x..x+WIDTH inclusive.
- `HEIGHT`, 32: sprite height; box spans y..y+HEIGHT inclusive.
- `SCREEN_W`, 1280 / `SCREEN_H`, 720: active area.
- `CENTER_X`, 512 / `CENTER_Y`, 384: lane coordinates and target point.
- `HIT_WINDOW`, 16: max |travel-axis position − target| for a hit.

- `clk` in 1: pixel clock.
- `rst_in` in 1: reset. One clock; reset is asynchronous and active-high.
- `hcount_in` in 11: current pixel x.
- `vcount_in` in 10: current pixel y.
- `spawn_valid_in` in 1: spawn request.
- `spawn_ready_out` out 1: a free slot exists.
- `spawn_direction_in` in 2: 00 down, 01 up, 10 right, 11 left.
- `spawn_speed_in` in 3: pixels moved per frame (0 = stationary).
- `hit_in` in 1: one-cycle player press.
- `hit_direction_in` in 2: direction pressed.
- `pixel_out` out 12: RGB444 of the topmost arrow, else 0.
- `valid_out` out 1: an arrow covers the current pixel.
- `hit_out` / `miss_out` out 1: one-cycle score pulses.
- `hit_count_out` / `miss_count_out` out 16: saturating totals.

## Operation
- Per slot: `active`, `dir`, `speed`, `x`[10:0], `y`[9:0].
- Spawn accepted when `spawn_valid_in && spawn_ready_out && !rst_in`. Target is the lowest-index free slot.
- `spawn_ready_out` is combinational: high when any `active` bit is 0, using registered state only. A slot freed this cycle is not reusable until the next cycle.
- Start positions by direction:
  - 00: (CENTER_X, 0)
  - 01: (CENTER_X, SCREEN_H−HEIGHT)
  - 10: (0, CENTER_Y)
  - 11: (SCREEN_W−WIDTH, CENTER_Y)
- Frame tick: `hcount_in==0 && vcount_in==0`. On a tick every active slot not spawned or hit this cycle advances by `speed`:
  - 00: y+speed
  - 01: y−speed
  - 10: x+speed
  - 11: x−speed
- Retire instead of moving when the next position would leave the screen. Conditions:
  - 00: y+speed ≥ SCREEN_H
  - 01: y < speed
  - 10: x+speed ≥ SCREEN_W
  - 11: x < speed
- A retired slot goes inactive and counts as a miss.
- Hit check on `hit_in`:
  - Candidates are active slots with `dir==hit_direction_in` and |p−T| ≤ HIT_WINDOW.
  - p and T: p=y, T=CENTER_Y for 00/01; p=x, T=CENTER_X for 10/11. Compare at 12-bit signed.
  - The lowest-index candidate is freed and counts as a hit.
  - If there is no candidate, the press is ignored (no pulse, no count).
- Counters: `hit_count_out` +1 per hit. `miss_count_out` + number of slots retired that cycle. Both saturate at 16'hFFFF.
- Pixel: the lowest-index active slot whose box contains (hcount_in, vcount_in) wins. Colours by direction: 00 F00, 01 0F0, 10 00F, 11 FF0.

## Timing
- Reset values: all slots inactive, counters 0, `pixel_out`=0, `valid_out`=0, `hit_out`=0, `miss_out`=0. After reset, `spawn_ready_out`=1.
- Reset asserted mid-frame clears everything immediately. In-flight arrows are dropped without miss counts.
- Pixel latency: 1 cycle. `pixel_out`/`valid_out` registered from the hcount/vcount of the previous cycle.
- `hit_out`, `miss_out` and counter updates appear 1 cycle after the deciding edge.
- Hit is evaluated on pre-move positions:
  - Hit and tick in the same cycle: the hit slot is freed and neither moved nor counted as a miss.
  - The other slots move normally; hit and miss may pulse together.
- Spawn on a tick cycle: the new arrow is placed at its start position and first moves on the next tick.

## Structure
- Package `arrow_pkg`: direction enum (DIR_DOWN/UP/RIGHT/LEFT), colour constants, slot struct typedef.
- Sub-module `arrow_slot`, instantiated NUM_ARROWS times. Contents: position/active registers, move/retire logic, box-hit test, target-window compare.
- Top-level contents: free-slot priority encoder, hit arbiter, pixel priority mux, counters.

## Test plan
- Reset then spawn dir 00, speed 4. Apply 10 ticks → y=40. Driving (512,40) gives `valid_out`=1, `pixel_out`=F00 one cycle later; (521,40) gives 0.
- Fill slots: 4 accepted spawns → `spawn_ready_out`=0 and a 5th valid is held. After one retire, ready=1 and the 5th lands in the freed index.
- Miss path: dir 01, speed 7, start y=688. After 98 ticks y=2; tick 99 → `miss_out` pulse, `miss_count_out`=1, slot free.
- Hit path: dir 10, speed 4, ticked until x=500; `hit_in` dir 10 → `hit_out`, `hit_count_out`=1. Same press with x=400 → no response.
- Simultaneous cases:
  - `hit_in` on a tick cycle with the hit arrow at its last on-screen position → hit counted, no miss.
  - Spawn on a tick cycle → arrow stays at its start position for one frame.
- Asynchronous reset mid-frame with 3 active arrows → all outputs 0 immediately, counters 0, no miss pulse.
